// File: rtl/front_panel_input_if.sv
// Front-panel control bundle between the raw panel side and the conditioning block.
// Latency: none, wires only.
// Backpressure: none; every signal is a free-running level.
interface front_panel_input_if;
    logic [3:0] sw_mode;
    logic       btn_step;
    logic       halt;
    logic [3:0] mode;
    logic       step;
    logic       halted;
    logic       mode_changed;

    // Panel / CPU side: drives raw controls and halt, observes conditioned outputs.
    modport master (
        output sw_mode,
        output btn_step,
        output halt,
        input  mode,
        input  step,
        input  halted,
        input  mode_changed
    );

    // Conditioning block side.
    modport slave (
        input  sw_mode,
        input  btn_step,
        input  halt,
        output mode,
        output step,
        output halted,
        output mode_changed
    );
endinterface

// File: rtl/front_panel_input.sv
// Debounces front-panel switches and step button, and adds a CPU halt latch that forces step mode.
// Latency: a steady raw change shows on the outputs DEBOUNCE_CYCLES+2 clocks after it is first sampled.
// Backpressure: none; the outputs are levels, and mode_changed is a one-cycle pulse.
module fpi_debounce #(
    parameter int W               = 1,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] raw,
    output logic [W-1:0] db
);
    logic [W-1:0]     sync1;
    logic [W-1:0]     sync2;
    logic [W-1:0]     cand;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] eff;

    // Two-flop synchronizer on the raw asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // The count only carries over while the synchronized value matches the one being timed;
    // any new value, including a third value, starts again from zero.
    always_comb begin
        eff = '0;
        if (sync2 == cand) begin
            eff = cnt;
        end
    end

    // Commit the synchronized value once it has differed steadily for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            db   <= '0;
            cand <= '0;
            cnt  <= '0;
        end else if (sync2 == db) begin
            cnt <= '0;
        end else if (eff == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            db  <= sync2;
            cnt <= '0;
        end else begin
            cnt  <= eff + CNT_W'(1);
            cand <= sync2;
        end
    end
endmodule

module front_panel_input #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                rst,
    front_panel_input_if.slave  bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

    logic [3:0] mode_db;
    logic       step_db;
    logic       halted_q;
    logic [3:0] mode_q;
    logic [3:0] prev_mode;

    // The whole switch bus shares one counter, so a partial change never commits.
    fpi_debounce #(
        .W               (4),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_mode_db (
        .clk (clk),
        .rst (rst),
        .raw (bus.sw_mode),
        .db  (mode_db)
    );

    fpi_debounce #(
        .W               (1),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_step_db (
        .clk (clk),
        .rst (rst),
        .raw (bus.btn_step),
        .db  (step_db)
    );

    // Halt latch: set by CPU halt in auto mode; the run switch going off clears it, and clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else if (!mode_db[3]) begin
            halted_q <= 1'b0;
        end else if (bus.halt) begin
            halted_q <= 1'b1;
        end
    end

    // While halted, the run bit is forced to 0 so the clock controller drops to manual step.
    always_comb begin
        mode_q = {mode_db[3] & ~halted_q, mode_db[2:0]};
    end

    // Previous output copy for change detection; reset to 0 so the reset edge itself is silent.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_mode <= '0;
        end else begin
            prev_mode <= mode_q;
        end
    end

    assign bus.mode         = mode_q;
    assign bus.step         = step_db;
    assign bus.halted       = halted_q;
    assign bus.mode_changed = (mode_q != prev_mode);
endmodule
